dram_arbiter: RTL and testbench

- Shares the single SDRAM controller command/data port between NUM_REQ requesters, e.g. VGA line fetch, CPU and DMA.
- One requester (PRIO_REQ, the VGA scan-out) has absolute priority, bounded by a starvation limit; the others are served round-robin.
- Exactly one burst transaction is outstanding at a time; the arbiter routes write and read data beats to and from the granted requester.
- Sits inside marvin, between the requesters and the SDRAM controller, in the 200 MHz SDRAM clock domain.

---
 rtl/dram_arbiter_pkg.sv | 25 ++
 rtl/dram_arbiter_rr_pick.sv | 30 +++
 rtl/dram_arbiter.sv | 174 +++++++++++++++++
 tb/tb_dram_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_arbiter_pkg.sv
// Shared types for the SDRAM port arbiter.
package dram_arbiter_pkg;

    // Default geometry used by the shared command/ID types.
    localparam int unsigned NumReqDefault = 4;
    localparam int unsigned AddrWDefault  = 24;
    localparam int unsigned LenWDefault   = 4;

    typedef enum logic [1:0] {
        StIdle,
        StCmd,
        StWdata,
        StRdata
    } arb_state_t;

    typedef logic [$clog2(NumReqDefault)-1:0] arb_id_t;

    // One burst command as issued by a requester.
    typedef struct packed {
        logic                    we;
        logic [AddrWDefault-1:0] addr;
        logic [LenWDefault-1:0]  len;
    } dram_cmd_t;

endpackage

// File: rtl/dram_arbiter_rr_pick.sv
// Round-robin picker: first valid index after rr_ptr, wrapping, skipping one excluded index.
module arb_rr_pick #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         valid,
    input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
    input  logic [$clog2(NUM_REQ)-1:0] excluded,
    output logic                       found,
    output logic [$clog2(NUM_REQ)-1:0] winner
);

    localparam int unsigned IdW = $clog2(NUM_REQ);

    logic [IdW-1:0] idx;

    // Scan rr_ptr+1 .. rr_ptr+NUM_REQ modulo NUM_REQ; first hit wins.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            idx = IdW'((32'(rr_ptr) + i) % NUM_REQ);
            if (!found && valid[idx] && idx != excluded) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/dram_arbiter.sv
// Shares one SDRAM controller port between NUM_REQ requesters: one priority
// requester with a starvation bound, the rest round-robin, one burst at a time.
module dram_arbiter
    import dram_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned ADDR_W       = 24,
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned LEN_W        = 4,
    parameter int unsigned PRIO_REQ     = 0,
    parameter int unsigned MAX_PRIO_RUN = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_REQ-1:0]                req_valid,
    output logic [NUM_REQ-1:0]                req_ready,
    input  logic [NUM_REQ-1:0]                req_we,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0]    req_addr,
    input  logic [NUM_REQ-1:0][LEN_W-1:0]     req_len,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]    req_wdata,
    output logic [NUM_REQ-1:0]                req_wready,
    output logic [NUM_REQ-1:0]                rsp_valid,
    output logic [DATA_W-1:0]                 rsp_rdata,
    output logic                              mem_cmd_valid,
    input  logic                              mem_cmd_ready,
    output logic                              mem_cmd_we,
    output logic [ADDR_W-1:0]                 mem_cmd_addr,
    output logic [LEN_W-1:0]                  mem_cmd_len,
    output logic [DATA_W-1:0]                 mem_wdata,
    input  logic                              mem_wready,
    input  logic [DATA_W-1:0]                 mem_rdata,
    input  logic                              mem_rvalid,
    output logic [$clog2(NUM_REQ)-1:0]        grant_id,
    output logic                              busy
);

    localparam int unsigned IdW   = $clog2(NUM_REQ);
    localparam int unsigned PrunW = $clog2(MAX_PRIO_RUN + 1);
    localparam logic [IdW-1:0]   PrioId = IdW'(PRIO_REQ);
    localparam logic [PrunW-1:0] MaxRun = PrunW'(MAX_PRIO_RUN);

    arb_state_t       state_q, state_d;
    logic [IdW-1:0]   grant_q, grant_d;
    logic [IdW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PrunW-1:0] prio_run_q, prio_run_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;

    logic             rr_found;
    logic [IdW-1:0]   rr_winner;
    logic             others_valid;
    logic             prio_wins;

    arb_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .valid    (req_valid),
        .rr_ptr   (rr_ptr_q),
        .excluded (PrioId),
        .found    (rr_found),
        .winner   (rr_winner)
    );

    // Priority requester wins unless it has used up its run while others wait.
    always_comb begin
        others_valid = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (i != PRIO_REQ && req_valid[i]) begin
                others_valid = 1'b1;
            end
        end
        prio_wins = req_valid[PRIO_REQ] && ((prio_run_q < MaxRun) || !others_valid);
    end

    // Next-state logic and all port outputs; outputs are zero outside their phase.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        rr_ptr_d      = rr_ptr_q;
        prio_run_d    = prio_run_q;
        cnt_d         = cnt_q;
        req_ready     = '0;
        req_wready    = '0;
        rsp_valid     = '0;
        rsp_rdata     = '0;
        mem_cmd_valid = 1'b0;
        mem_cmd_we    = 1'b0;
        mem_cmd_addr  = '0;
        mem_cmd_len   = '0;
        mem_wdata     = '0;
        unique case (state_q)
            StIdle: begin
                if (prio_wins) begin
                    grant_d = PrioId;
                    if (prio_run_q < MaxRun) begin
                        prio_run_d = prio_run_q + 1'b1;
                    end
                    state_d = StCmd;
                end else if (rr_found) begin
                    grant_d    = rr_winner;
                    rr_ptr_d   = rr_winner;
                    prio_run_d = '0;
                    state_d    = StCmd;
                end
            end
            StCmd: begin
                mem_cmd_valid = 1'b1;
                mem_cmd_we    = req_we[grant_q];
                mem_cmd_addr  = req_addr[grant_q];
                mem_cmd_len   = req_len[grant_q];
                if (mem_cmd_ready) begin
                    req_ready[grant_q] = 1'b1;
                    cnt_d              = req_len[grant_q];
                    state_d            = req_we[grant_q] ? StWdata : StRdata;
                end
            end
            StWdata: begin
                mem_wdata           = req_wdata[grant_q];
                req_wready[grant_q] = mem_wready;
                if (mem_wready) begin
                    // cnt holds beats remaining minus one; zero marks the last beat.
                    if (cnt_q == '0) begin
                        state_d = StIdle;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            StRdata: begin
                rsp_valid[grant_q] = mem_rvalid;
                rsp_rdata          = mem_rdata;
                if (mem_rvalid) begin
                    if (cnt_q == '0) begin
                        state_d = StIdle;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State register with synchronous reset; a reset abandons any transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            grant_q    <= '0;
            rr_ptr_q   <= PrioId;
            prio_run_q <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            prio_run_q <= prio_run_d;
            cnt_q      <= cnt_d;
        end
    end

    assign grant_id = grant_q;
    assign busy     = (state_q != StIdle);

`ifndef SYNTHESIS
    // Stray data beats are ignored by the FSM; flag them here.
    assert property (@(posedge clk) disable iff (rst) mem_wready |-> state_q == StWdata)
        else $error("mem_wready outside write data phase");
    assert property (@(posedge clk) disable iff (rst) mem_rvalid |-> state_q == StRdata)
        else $error("mem_rvalid outside read data phase");
    // A requester must hold its request until accepted.
    assert property (@(posedge clk) disable iff (rst) state_q == StCmd |-> req_valid[grant_q])
        else $error("req_valid dropped before req_ready");
`endif

endmodule

// File: tb/tb_dram_arbiter.sv
// Directed bench for dram_arbiter with a small SDRAM controller responder.
module tb_dram_arbiter;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [3:0]       req_valid, req_ready, req_we, req_wready, rsp_valid;
    logic [3:0][23:0] req_addr;
    logic [3:0][3:0]  req_len;
    logic [3:0][15:0] req_wdata;
    logic [15:0]      rsp_rdata, mem_wdata, mem_rdata;
    logic             mem_cmd_valid, mem_cmd_ready, mem_cmd_we;
    logic [23:0]      mem_cmd_addr;
    logic [3:0]       mem_cmd_len;
    logic             mem_wready, mem_rvalid, busy;
    logic [1:0]       grant_id;

    int   n_checks = 0;
    int   n_errors = 0;
    int   grants[$];
    logic wr_toggle = 1'b0;
    logic [15:0] rd_base = 16'h0000;

    int exp_rr[6]    = '{1, 2, 3, 1, 2, 3};
    int exp_prio[10] = '{0, 0, 0, 0, 3, 0, 0, 0, 0, 3};

    dram_arbiter #(
        .NUM_REQ      (4),
        .ADDR_W       (24),
        .DATA_W       (16),
        .LEN_W        (4),
        .PRIO_REQ     (0),
        .MAX_PRIO_RUN (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_we        (req_we),
        .req_addr      (req_addr),
        .req_len       (req_len),
        .req_wdata     (req_wdata),
        .req_wready    (req_wready),
        .rsp_valid     (rsp_valid),
        .rsp_rdata     (rsp_rdata),
        .mem_cmd_valid (mem_cmd_valid),
        .mem_cmd_ready (mem_cmd_ready),
        .mem_cmd_we    (mem_cmd_we),
        .mem_cmd_addr  (mem_cmd_addr),
        .mem_cmd_len   (mem_cmd_len),
        .mem_wdata     (mem_wdata),
        .mem_wready    (mem_wready),
        .mem_rdata     (mem_rdata),
        .mem_rvalid    (mem_rvalid),
        .grant_id      (grant_id),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Wait (bounded) for the arbiter to go idle, then step to the next drive point.
    task automatic wait_idle(input int budget);
        bit ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check_eq("idle_timeout", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
    endtask

    // Collect grant order from req_ready pulses; optionally drop each request once accepted.
    task automatic run_until(input int n, input bit drop, input int budget);
        logic [3:0] prev = 4'b0;
        logic [3:0] mask;
        for (int c = 0; c < budget && grants.size() < n; c++) begin
            @(negedge clk);
            mask = 4'b0;
            if (req_ready != 4'b0) begin
                check_eq("ready_onehot", 64'($onehot(req_ready)), 64'd1);
                check_eq("ready_one_cycle", 64'(prev), 64'd0);
                for (int i = 0; i < 4; i++) if (req_ready[i]) grants.push_back(i);
                mask = req_ready;
            end
            prev = req_ready;
            @(posedge clk);
            #1;
            if (drop) req_valid = req_valid & ~mask;
        end
        if (grants.size() < n) check_eq("grant_timeout", 64'(grants.size()), 64'(n));
        if (!drop) req_valid = 4'b0;
        wait_idle(budget);
    endtask

    // Controller responder: accepts every command, then supplies/consumes its beats.
    initial begin
        int   left;
        int   k;
        logic cwe, ph, fire, ab;
        mem_cmd_ready = 1'b1;
        mem_wready    = 1'b0;
        mem_rvalid    = 1'b0;
        mem_rdata     = 16'h0;
        forever begin
            @(negedge clk);
            if (!rst && mem_cmd_valid && mem_cmd_ready) begin
                cwe  = mem_cmd_we;
                left = int'(mem_cmd_len) + 1;
                k    = 0;
                ph   = 1'b0;
                @(posedge clk);
                #1;
                while (left > 0) begin
                    if (cwe) begin
                        mem_wready = wr_toggle ? ph : 1'b1;
                        fire       = mem_wready;
                    end else begin
                        mem_rvalid = 1'b1;
                        mem_rdata  = rd_base + 16'(k);
                        fire       = 1'b1;
                    end
                    @(posedge clk);
                    ab = rst;
                    #1;
                    if (fire) begin
                        left--;
                        k++;
                    end
                    ph = ~ph;
                    if (ab) left = 0;
                end
                mem_wready = 1'b0;
                mem_rvalid = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int  k;
        int  beats;
        bit  started;
        bit  dropped;
        req_valid = 4'b0;
        req_we    = 4'b1111;
        req_addr  = '0;
        req_len   = '0;
        req_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check_eq("reset_outs", 64'({busy, mem_cmd_valid, mem_cmd_we, mem_cmd_len, req_ready,
                 req_wready, rsp_valid, rsp_rdata, grant_id, mem_wdata}), 64'd0);
        check_eq("reset_addr", 64'(mem_cmd_addr), 64'd0);
        @(posedge clk);
        #1;

        // Round-robin among 1..3, single-beat writes
        req_valid = 4'b1110;
        run_until(6, 1'b0, 100);
        for (int i = 0; i < 6; i++)
            check_eq($sformatf("rr_grant%0d", i), 64'((i < grants.size()) ? grants[i] : 99),
                     64'(exp_rr[i]));
        grants.delete();

        // Single 4-beat read by requester 2
        rd_base      = 16'h00A0;
        req_we[2]    = 1'b0;
        req_len[2]   = 4'd3;
        req_addr[2]  = 24'h000100;
        req_valid[2] = 1'b1;
        @(negedge clk);
        check_eq("rd_idle_cycle", 64'(mem_cmd_valid), 64'd0);
        @(negedge clk);
        check_eq("rd_cmd_valid", 64'(mem_cmd_valid), 64'd1);
        check_eq("rd_cmd_addr", 64'(mem_cmd_addr), 64'h100);
        check_eq("rd_cmd_len", 64'(mem_cmd_len), 64'd3);
        check_eq("rd_cmd_we", 64'(mem_cmd_we), 64'd0);
        check_eq("rd_req_ready", 64'(req_ready), 64'b0100);
        check_eq("rd_grant", 64'(grant_id), 64'd2);
        @(posedge clk);
        #1;
        req_valid = 4'b0;
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            check_eq($sformatf("rd_valid%0d", b), 64'(rsp_valid), 64'b0100);
            check_eq($sformatf("rd_data%0d", b), 64'(rsp_rdata), 64'(16'h00A0 + 16'(b)));
        end
        @(negedge clk);
        check_eq("rd_busy_drop", 64'(busy), 64'd0);
        check_eq("rd_valid_drop", 64'(rsp_valid), 64'd0);
        check_eq("rd_grant_hold", 64'(grant_id), 64'd2);
        @(posedge clk);
        #1;
        req_we  = 4'b1111;
        req_len = '0;

        // Priority with starvation bound: 0 and 3 continuously valid
        req_valid = 4'b1001;
        run_until(10, 1'b0, 200);
        for (int i = 0; i < 10; i++)
            check_eq($sformatf("prio_grant%0d", i), 64'((i < grants.size()) ? grants[i] : 99),
                     64'(exp_prio[i]));
        grants.delete();

        // 16-beat write by requester 1 with toggling back-pressure
        wr_toggle    = 1'b1;
        req_len[1]   = 4'hF;
        req_wdata[1] = 16'h1000;
        req_valid[1] = 1'b1;
        k       = 0;
        started = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            dropped = req_ready[1];
            if (req_wready[1]) begin
                check_eq($sformatf("wr_data%0d", k), 64'(mem_wdata), 64'(16'h1000 + 16'(k)));
                k++;
            end
            if (busy) started = 1'b1;
            if (started && !busy) break;
            @(posedge clk);
            #1;
            if (dropped) req_valid[1] = 1'b0;
            req_wdata[1] = 16'h1000 + 16'(k);
        end
        check_eq("wr_beat_count", 64'(k), 64'd16);
        check_eq("wr_back_idle", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        wr_toggle  = 1'b0;
        req_len[1] = 4'd0;

        // Simultaneous 0 and 2 with prio_run = 0
        req_valid = 4'b0101;
        run_until(2, 1'b1, 40);
        check_eq("sim_first", 64'((grants.size() > 0) ? grants[0] : 99), 64'd0);
        check_eq("sim_second", 64'((grants.size() > 1) ? grants[1] : 99), 64'd2);
        grants.delete();

        // Reset during the 3rd beat of an 8-beat read by requester 2
        rd_base      = 16'h00B0;
        req_we[2]    = 1'b0;
        req_len[2]   = 4'd7;
        req_valid[2] = 1'b1;
        beats        = 0;
        for (int c = 0; c < 20 && beats < 2; c++) begin
            @(negedge clk);
            dropped = req_ready[2];
            if (rsp_valid[2]) beats++;
            @(posedge clk);
            #1;
            if (dropped) req_valid[2] = 1'b0;
        end
        check_eq("rst_pre_beats", 64'(beats), 64'd2);
        rst = 1'b1;
        @(negedge clk);
        check_eq("rst_beat3_valid", 64'(rsp_valid), 64'b0100);
        check_eq("rst_beat3_data", 64'(rsp_rdata), 64'h00B2);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_outs", 64'({busy, mem_cmd_valid, mem_cmd_we, mem_cmd_len, req_ready,
                 req_wready, rsp_valid, rsp_rdata, grant_id, mem_wdata}), 64'd0);
        check_eq("rst_addr", 64'(mem_cmd_addr), 64'd0);
        @(posedge clk);
        #1;
        req_we    = 4'b1111;
        req_len   = '0;

        // Fresh requests after reset: round-robin restarts after index 0
        req_valid = 4'b1010;
        run_until(2, 1'b1, 40);
        check_eq("post_rst_first", 64'((grants.size() > 0) ? grants[0] : 99), 64'd1);
        check_eq("post_rst_second", 64'((grants.size() > 1) ? grants[1] : 99), 64'd3);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
